// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction fetch controller.
package fetch_ctrl_pkg;

  localparam int WORD_W      = 64;
  localparam int INST_W      = 32;
  localparam int FETCH_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_fifo.sv
// Two-entry fetch buffer; head is a register so decode sees stable data while stalled.
module fetch_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = WORD_W + INST_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  assign full  = (count_q == 2'(FETCH_DEPTH));
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign head  = head_q;

  // Flush wins over everything; a pop on an empty buffer is treated as no pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop && !empty})
        2'b10: begin
          if (count_q == 2'd0) head_d = din;
          else if (count_q == 2'd1) tail_d = din;
          if (!full) count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = din;
          end else begin
            head_d = tail_q;
            tail_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: run/halt FSM, PC register and sticky misaligned-redirect flag
// feeding a two-entry buffer toward decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int             WORD      = WORD_W,
  parameter int             INST_SIZE = INST_W,
  parameter logic [WORD-1:0] RESET_PC = 64'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt_req,
  output logic [WORD-1:0]      imem_pc,
  input  logic [INST_SIZE-1:0] imem_inst,
  input  logic                 br_taken,
  input  logic [WORD-1:0]      br_target,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [WORD-1:0]      if_pc,
  output logic [INST_SIZE-1:0] if_inst,
  output logic                 fetch_err,
  output logic                 busy
);

  fetch_state_e    state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic            err_q, err_d;

  logic                      push, pop, flush;
  logic                      fifo_full, fifo_empty;
  logic [1:0]                fifo_count;
  logic [WORD+INST_SIZE-1:0] fifo_head;

  fetch_fifo #(.WIDTH(WORD + INST_SIZE)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({pc_q, imem_inst}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign imem_pc   = pc_q;
  assign if_valid  = (fifo_count != 2'd0);
  assign if_pc     = fifo_head[WORD+INST_SIZE-1:INST_SIZE];
  assign if_inst   = fifo_head[INST_SIZE-1:0];
  assign fetch_err = err_q;
  assign busy      = (state_q == RUN);

  // A redirect both flushes and suppresses the push; in IDLE the buffer is already empty.
  always_comb begin
    pop   = !fifo_empty && if_ready;
    flush = br_taken && (state_q != IDLE);
    push  = (state_q == RUN) && !halt_req && !br_taken && (!fifo_full || pop);

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (halt_req) state_d = HALT;
      HALT:    if (start)    state_d = RUN;
      default:               state_d = IDLE;
    endcase

    pc_d = pc_q;
    if (br_taken)  pc_d = {br_target[WORD-1:2], 2'b00};
    else if (push) pc_d = pc_q + WORD'(4);

    err_d = err_q || (br_taken && (br_target[1:0] != 2'b00));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The parameter WORD SHALL default to 64 and set the PC width.
REQ-002 The parameter INST_SIZE SHALL default to 32 and set the instruction width.
REQ-003 The parameter RESET_PC SHALL default to 64'd0 and set the PC value after reset.
REQ-004 The port list SHALL be, in order:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: leave IDLE or HALT and begin fetching.
- halt_req, input, 1: stop fetching.
- imem_pc, output, WORD: address to inst_mem.
- imem_inst, input, INST_SIZE: combinational read data from inst_mem.
- br_taken, input, 1: redirect request.
- br_target, input, WORD: redirect address.
- if_valid, output, 1: buffered instruction available to decode.
- if_ready, input, 1: decode accepts.
- if_pc, output, WORD: PC of the head entry.
- if_inst, output, INST_SIZE: instruction of the head entry.
- fetch_err, output, 1: sticky misaligned-redirect flag.
- busy, output, 1: state is RUN.

Function
REQ-005 The block SHALL hold a PC register and drive imem_pc combinationally from it.
REQ-006 The FSM SHALL have exactly three states, IDLE, RUN and HALT, with these transitions:
- IDLE->RUN on start.
- RUN->HALT on halt_req.
- HALT->RUN on start.
- Every other combination holds the current state.
REQ-007 In RUN, when push is allowed, the block SHALL push {pc, imem_inst} into a 2-entry FIFO and advance pc by 4 on the same edge.
REQ-008 Push SHALL be allowed when count<2, or when count==2 and a pop occurs in the same cycle.
REQ-009 The if_valid output SHALL equal (count!=0), and if_pc/if_inst SHALL present the head entry.
REQ-010 A pop SHALL occur exactly when if_valid && if_ready; the head SHALL hold stable while if_valid && !if_ready.
REQ-011 A cycle with br_taken in RUN or HALT SHALL, on the next edge:
- flush the FIFO (count=0);
- set pc={br_target[WORD-1:2],2'b00};
- suppress that cycle's push.
A same-cycle pop SHALL be discarded by the flush.
REQ-012 br_taken in IDLE SHALL update pc only; the FIFO is already empty.
REQ-013 A br_taken with br_target[1:0]!=0 SHALL set fetch_err, which then stays 1 until reset.
REQ-014 halt_req together with br_taken SHALL apply both: the state becomes HALT and the redirect and flush happen.
REQ-015 The halt_req input SHALL block pushes from the same cycle onward. Entries already buffered SHALL remain poppable in HALT.
REQ-016 The start input SHALL be ignored in RUN, and halt_req SHALL be ignored in IDLE and HALT.
REQ-017 PC arithmetic SHALL be modulo 2^WORD: 0xFFFF_FFFF_FFFF_FFFC+4 wraps to 0 with no flag.
REQ-018 Latency:
- start sampled at edge N gives RUN after N.
- The first push occurs at edge N+1.
- if_valid=1 with if_pc=RESET_PC after edge N+1.
REQ-019 The busy output SHALL be 1 exactly when the state is RUN.

Reset
REQ-020 Assertion of rst_n=0 SHALL immediately, without a clock, force:
- state=IDLE;
- pc=RESET_PC, so imem_pc=RESET_PC;
- count=0, if_valid=0;
- fetch_err=0, busy=0.
REQ-021 Reset SHALL be allowed in any state, including mid-stall with a full FIFO, and SHALL discard all buffered entries.
REQ-022 Deassertion of rst_n SHALL be treated as synchronous to clk by the system; the first fetch SHALL still require start.

Structure
REQ-023 The shared header common.vh SHALL hold:
- WORD, INST_SIZE;
- the FETCH_DEPTH=2 constant;
- the fetch state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2).
REQ-024 The FIFO SHALL be a sub-module named fetch_fifo with these properties:
- WIDTH=WORD+INST_SIZE, depth 2;
- ports push, pop, flush, full, empty, count, head;
- flush takes priority over push and pop.
REQ-025 The fetch_ctrl top SHALL contain only the FSM, the PC register and the error flag. All storage SHALL be registered; there is no combinational path from if_ready to imem_pc.

Verification
REQ-026 Use inst_mem preloaded with inst==pc/4. Stimulus: start=1 pulse, if_ready=1. Required response: if_valid from the second edge, if_pc=0,4,8,... every cycle, if_inst=if_pc/4, 64 entries.
REQ-027 Stimulus: if_ready=0 after start. Required response: count saturates at 2 holding pc 0 and 4, with imem_pc frozen at 8. Raising if_ready resumes with 8, with no duplicate or lost entry.
REQ-028 Stimulus: br_taken with br_target=0x100 while the FIFO holds 2 entries and if_ready=1. Required response: next cycle if_valid=0, then if_pc=0x100 and if_inst=0x40.
REQ-029 Stimulus: br_target=0x102. Required response: fetch_err=1 and stays 1, and the fetch resumes at 0x100.
REQ-030 Stimulus: halt_req in RUN with the FIFO full. Required response: the 2 entries drain, no new push, busy=0; then start resumes at the next sequential PC.
REQ-031 Stimulus: rst_n=0 asserted mid-clock with a full FIFO. Required response: immediate if_valid=0, imem_pc=0, fetch_err=0, and the state stays IDLE until start.
